sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Single-clock, fully parametrised FIFO for buffering data words between producer and consumer logic in one clock domain. It is the single-clock successor to the team's dual-clock FIFO and adds:
- arbitrary (non-power-of-two) depth;
- configurable almost-full and almost-empty thresholds;
- an occupancy count output;
- a selectable first-word-fall-through read mode;
- sticky overflow and underflow error flags.

## Interface
- DWIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of storage entries (≥2; need not be a power of two)
- AFULL_TH, 12, almost_full asserts when count ≥ AFULL_TH (1 ≤ AFULL_TH ≤ DEPTH)
- AEMPTY_TH, 4, almost_empty asserts when count ≤ AEMPTY_TH (0 ≤ AEMPTY_TH < DEPTH)
- FWFT, 0, 0 = standard read (registered, 1-cycle latency); 1 = first-word-fall-through
- clk  input  1  sole clock; all state updates on its rising edge
- reset_L  input  1  asynchronous, active-low reset
- push  input  1  write request
- wdata  input  DWIDTH  write data, sampled with push
- full  output  1  no free entries
- almost_full  output  1  count ≥ AFULL_TH
- pop  input  1  read request
- rdata  output  DWIDTH  read data
- empty  output  1  no readable entries
- almost_empty  output  1  count ≤ AEMPTY_TH
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- clr_err  input  1  synchronous clear of overflow/underflow
- overflow  output  1  sticky: push attempted while full
- underflow  output  1  sticky: pop attempted while empty

## Operation
- **Storage and pointers.** Storage is DEPTH entries. Write and read pointers are $clog2(DEPTH) bits wide. Each pointer wraps from DEPTH-1 to 0 by explicit compare, not by natural overflow. Storage contents are not reset.
- **Accept rules.**
  - A push is accepted iff push=1 and full=0. The accepted word is written at the write pointer, and the write pointer advances.
  - A pop is accepted iff pop=1 and empty=0. The read pointer advances.
  - No pass-through: a push while full is rejected even if a pop is accepted in the same cycle. A pop while empty is rejected even if a push is accepted in the same cycle.
- **count update** (registered, per edge):
  - +1 for an accepted push alone;
  - −1 for an accepted pop alone;
  - unchanged when both are accepted or neither is.
- **Flags.** All flags are registered and decoded from the next value of count, so they are exact in the same cycle count changes: empty = (count==0), full = (count==DEPTH), plus almost_full and almost_empty per their thresholds.
- **Errors.**
  - A rejected push (push=1, full=1) sets overflow.
  - A rejected pop (pop=1, empty=1) sets underflow.
  - clr_err=1 clears both flags at the next edge. If a new error occurs in the same cycle as clr_err, the set wins.
  - Errors never alter pointers, count or data.
- **Standard mode (FWFT=0).** rdata is a register. On an accepted pop it loads the entry at the read pointer at that edge. It holds otherwise.
- **FWFT mode (FWFT=1).** rdata continuously presents the entry at the read pointer and is valid whenever empty=0. pop acknowledges/consumes the presented word, and the next word (if any) appears after the edge. The rdata value while empty=1 is don't-care.
- **Reset** (asynchronous assert, any time, including mid-operation):
  - all contents are logically discarded and both pointers go to 0;
  - output values: count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rdata=0 in standard mode.
  - Deassertion is assumed synchronised externally. The first operation is accepted at the first rising edge after reset_L=1.

## Timing
- push → flags: accepted push at edge N gives count, empty, full and almost_* updated after edge N (visible in cycle N+1).
- Standard read: pop accepted at edge N gives the word on rdata after edge N; rdata is stable until the next accepted pop.
- FWFT read: push into an empty FIFO at edge N gives empty=0 and rdata = that word in cycle N+1. A pop at edge M presents the next word in cycle M+1.
- Throughput: one push and one pop per cycle sustained, with no bubbles, at any occupancy except the full and empty limits.
- Full boundary: with count=DEPTH, push+pop in one cycle gives the pop accepted, the push rejected, overflow set and count=DEPTH-1.
- Empty boundary: with count=0, push+pop gives the push accepted, underflow set and count=1.

## Test plan
- Reset, then DEPTH=16 and FWFT=0: push 0x01..0x10 on 16 consecutive cycles gives full=1 and count=16; almost_full rises in the cycle after the 12th push. Then pop ×16 returns 0x01..0x10 in order, each 1 cycle after its pop, and ends with empty=1 and count=0.
- DEPTH=6, 20 cycles of simultaneous push/pop at count=3 (pointers wrap several times) gives count constant at 3 and data in FIFO order with no loss or duplication.
- Full with push+pop in one cycle gives count 16→15 and overflow=1. A later clr_err=1 alone gives overflow=0. clr_err together with a new overflow gives overflow=1.
- Empty with pop=1 gives underflow=1, count=0 and rdata unchanged. Empty with push=1 (0xA5) and pop=1 gives count=1 and underflow=1.
- FWFT=1: push 0x3C into an empty FIFO gives empty=0 and rdata=0x3C the next cycle without a pop. pop gives empty=1 the next cycle.
- reset_L pulsed low mid-burst at count=9 gives count=0, empty=1, overflow=underflow=0 immediately (asynchronously). After release, the next push/pop returns the newly pushed word, not stale data.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/almost-empty thresholds,
// occupancy count, optional first-word-fall-through read and sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AFULL_TH  = 12,
    parameter int unsigned AEMPTY_TH = 4,
    parameter bit          FWFT      = 1'b0,
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic [DWIDTH-1:0] wdata,
    output logic              full,
    output logic              almost_full,
    input  logic              pop,
    output logic [DWIDTH-1:0] rdata,
    output logic              empty,
    output logic              almost_empty,
    output logic [CW-1:0]     count,
    input  logic              clr_err,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AW-1:0] LastIdx  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
    localparam logic [CW-1:0] AfullCnt = CW'(AFULL_TH);
    localparam logic [CW-1:0] AemptyCnt = CW'(AEMPTY_TH);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic push_acc;
    logic pop_acc;

    // Accepts look only at the current flags, so there is no pass-through at the limits.
    assign push_acc = push & ~full_q;
    assign pop_acc  = pop & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_acc) begin
            wr_ptr_d = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + AW'(1);
        end
        if (pop_acc) begin
            rd_ptr_d = (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + AW'(1);
        end

        unique case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Flags decode the next count so they are exact in the cycle the count changes.
    always_comb begin
        full_d   = (count_d == DepthCnt);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AfullCnt);
        aempty_d = (count_d <= AemptyCnt);
    end

    // A new error in the same cycle as clr_err wins over the clear.
    always_comb begin
        ovf_d = (push & full_q) | (ovf_q & ~clr_err);
        unf_d = (pop & empty_q) | (unf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is intentionally not reset; the pointers alone define what is readable.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign rdata = mem_q[rd_ptr_q];
        end else begin : g_std
            logic [DWIDTH-1:0] rdata_q;

            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    rdata_q <= '0;
                end else if (pop_acc) begin
                    rdata_q <= mem_q[rd_ptr_q];
                end
            end

            assign rdata = rdata_q;
        end
    endgenerate

    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives three FIFO configurations with shared directed and random stimulus and checks every
// cycle against a word-history model (pushed words minus consumed words).
module tb_sync_fifo_param;

    localparam int NI = 3;
    localparam int HN = 8192;
    localparam int DEP [NI] = '{16, 6, 6};
    localparam int AFT [NI] = '{12, 5, 4};
    localparam int AET [NI] = '{4, 1, 2};
    localparam int FW  [NI] = '{0, 1, 0};

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       push = 1'b0;
    logic [7:0] wdata = '0;
    logic       pop = 1'b0;
    logic       clr_err = 1'b0;

    logic [4:0] cnt_a;
    logic [2:0] cnt_b, cnt_c;
    logic [7:0] cnt [NI];
    logic [7:0] rd [NI];
    logic       fl [NI], ef [NI], af [NI], ae [NI], ov [NI], uf [NI];

    int         n_vec = 0;
    int         n_err = 0;
    logic       chk_en = 1'b0;

    int         npush [NI];
    int         npop [NI];
    logic [7:0] hist [NI][HN];
    logic [7:0] m_rd [NI];
    logic       m_ov [NI];
    logic       m_uf [NI];

    always #5 clk = ~clk;

    sync_fifo_param #(.DWIDTH(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(1'b0)) u_a (
        .clk(clk), .reset_L(reset_L), .push(push), .wdata(wdata), .full(fl[0]),
        .almost_full(af[0]), .pop(pop), .rdata(rd[0]), .empty(ef[0]), .almost_empty(ae[0]),
        .count(cnt_a), .clr_err(clr_err), .overflow(ov[0]), .underflow(uf[0])
    );
    sync_fifo_param #(.DWIDTH(8), .DEPTH(6), .AFULL_TH(5), .AEMPTY_TH(1), .FWFT(1'b1)) u_b (
        .clk(clk), .reset_L(reset_L), .push(push), .wdata(wdata), .full(fl[1]),
        .almost_full(af[1]), .pop(pop), .rdata(rd[1]), .empty(ef[1]), .almost_empty(ae[1]),
        .count(cnt_b), .clr_err(clr_err), .overflow(ov[1]), .underflow(uf[1])
    );
    sync_fifo_param #(.DWIDTH(8), .DEPTH(6), .AFULL_TH(4), .AEMPTY_TH(2), .FWFT(1'b0)) u_c (
        .clk(clk), .reset_L(reset_L), .push(push), .wdata(wdata), .full(fl[2]),
        .almost_full(af[2]), .pop(pop), .rdata(rd[2]), .empty(ef[2]), .almost_empty(ae[2]),
        .count(cnt_c), .clr_err(clr_err), .overflow(ov[2]), .underflow(uf[2])
    );

    assign cnt[0] = {3'b000, cnt_a};
    assign cnt[1] = {5'b00000, cnt_b};
    assign cnt[2] = {5'b00000, cnt_c};

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d] at %0t: got %0h, want %0h", nm, k, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NI; k++) begin
            npush[k] = 0;
            npop[k]  = 0;
            m_rd[k]  = '0;
            m_ov[k]  = 1'b0;
            m_uf[k]  = 1'b0;
        end
    endtask

    // Apply one cycle of inputs, update the model at the edge, return at the next falling edge.
    task automatic step(input logic ps, input logic [7:0] wd, input logic pp, input logic cl);
        push = ps;
        wdata = wd;
        pop = pp;
        clr_err = cl;
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            int sz;
            bit is_full, is_empty;
            sz = npush[k] - npop[k];
            is_full = (sz == DEP[k]);
            is_empty = (sz == 0);
            if (ps && is_full) m_ov[k] = 1'b1;
            else if (cl) m_ov[k] = 1'b0;
            if (pp && is_empty) m_uf[k] = 1'b1;
            else if (cl) m_uf[k] = 1'b0;
            if (pp && !is_empty) begin
                m_rd[k] = hist[k][npop[k] % HN];
                npop[k]++;
            end
            if (ps && !is_full) begin
                hist[k][npush[k] % HN] = wd;
                npush[k]++;
            end
        end
        @(negedge clk);
    endtask

    int cs;
    always @(negedge clk) begin
        if (chk_en && reset_L) begin
            for (int k = 0; k < NI; k++) begin
                cs = npush[k] - npop[k];
                chk("count", k, int'(cnt[k]), cs);
                chk("empty", k, int'(ef[k]), int'(cs == 0));
                chk("full", k, int'(fl[k]), int'(cs == DEP[k]));
                chk("almost_full", k, int'(af[k]), int'(cs >= AFT[k]));
                chk("almost_empty", k, int'(ae[k]), int'(cs <= AET[k]));
                chk("overflow", k, int'(ov[k]), int'(m_ov[k]));
                chk("underflow", k, int'(uf[k]), int'(m_uf[k]));
                if (FW[k] == 0) chk("rdata", k, int'(rd[k]), int'(m_rd[k]));
                else if (cs > 0) chk("rdata_fwft", k, int'(rd[k]), int'(hist[k][npop[k] % HN]));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_count", 0, int'(cnt[0]), 0);
        chk("rst_empty", 0, int'(ef[0]), 1);
        chk("rst_aempty", 0, int'(ae[0]), 1);
        chk("rst_full", 0, int'(fl[0]), 0);
        chk("rst_afull", 0, int'(af[0]), 0);
        chk("rst_ovf", 0, int'(ov[0]), 0);
        chk("rst_unf", 0, int'(uf[0]), 0);
        chk("rst_rdata", 0, int'(rd[0]), 0);
        reset_L = 1'b1;
        chk_en = 1'b1;

        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 11) chk("afull_at11", 0, int'(af[0]), 0);
            if (i == 12) chk("afull_at12", 0, int'(af[0]), 1);
        end
        chk("fill_full", 0, int'(fl[0]), 1);
        chk("fill_count", 0, int'(cnt[0]), 16);
        chk("small_ovf", 2, int'(ov[2]), 1);

        step(1'b1, 8'h11, 1'b1, 1'b0);
        chk("bound_count", 0, int'(cnt[0]), 15);
        chk("bound_ovf", 0, int'(ov[0]), 1);
        chk("bound_rdata", 0, int'(rd[0]), 8'h01);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", 0, int'(ov[0]), 0);
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h12, 1'b0, 1'b1);
        chk("clr_vs_set", 0, int'(ov[0]), 1);

        repeat (16) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_empty", 0, int'(ef[0]), 1);
        chk("drain_count", 0, int'(cnt[0]), 0);
        chk("drain_last", 0, int'(rd[0]), 8'h11);

        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_set", 0, int'(uf[0]), 1);
        chk("unf_count", 0, int'(cnt[0]), 0);
        chk("unf_rdata", 0, int'(rd[0]), 8'h11);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        chk("emptyb_count", 0, int'(cnt[0]), 1);
        chk("emptyb_unf", 0, int'(uf[0]), 1);

        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("fwft_empty", 1, int'(ef[1]), 0);
        chk("fwft_rdata", 1, int'(rd[1]), 8'h3C);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fwft_drain", 1, int'(ef[1]), 1);

        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
        chk("wrap_count", 2, int'(cnt[2]), 3);
        chk("wrap_rdata", 2, int'(rd[2]), 8'h50);
        chk("wrap_count_fwft", 1, int'(cnt[1]), 3);

        for (int seg = 0; seg < 4; seg++) begin
            int pp_pct, pq_pct;
            pp_pct = (seg == 0) ? 70 : (seg == 1) ? 30 : (seg == 2) ? 50 : 90;
            pq_pct = (seg == 0) ? 30 : (seg == 1) ? 70 : (seg == 2) ? 50 : 90;
            for (int i = 0; i < 500; i++) begin
                step(1'($urandom_range(99) < pp_pct), 8'($urandom), 1'($urandom_range(99) < pq_pct),
                     1'($urandom_range(99) < 3));
            end
        end

        repeat (20) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        chk("pre_rst_count", 0, int'(cnt[0]), 9);
        #2;
        reset_L = 1'b0;
        model_clear();
        #1;
        chk("async_count", 0, int'(cnt[0]), 0);
        chk("async_empty", 0, int'(ef[0]), 1);
        chk("async_ovf", 0, int'(ov[0]), 0);
        chk("async_unf", 0, int'(uf[0]), 0);
        chk("async_rdata", 0, int'(rd[0]), 0);
        @(negedge clk);
        reset_L = 1'b1;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        chk("post_rst_fwft", 1, int'(rd[1]), 8'h77);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_rdata", 0, int'(rd[0]), 8'h77);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
